// File: rtl/adc_settle_avg.sv
// Per-channel settle-and-average stage: drops SETTLE_CNT conversions after each mux change,
// then averages 2^LOG2_AVG conversions. Define ADC_AVG_ROUND_EN for round-half-up instead of truncation.
//
// state  | meaning
// IDLE   | waiting for ch_start; sample_valid ignored
// SETTLE | discarding conversions while the analog path settles
// ACCUM  | summing conversions for the current channel
// OUTPUT | one-cycle avg_valid with registered result
module adc_settle_avg #(
   parameter int DATA_W     = 12,
   parameter int ADDR_W     = 6,
   parameter int SETTLE_CNT = 2,
   parameter int LOG2_AVG   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ch_start,
   input  logic [ADDR_W-1:0] ch_addr,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   output logic              avg_valid,
   output logic [DATA_W-1:0] avg_data,
   output logic [ADDR_W-1:0] avg_addr,
   output logic              busy,
   output logic              overrun
);

   localparam int ACC_W = DATA_W + LOG2_AVG + 1;
   localparam int SET_W = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
   localparam int AVG_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE_CNT > 0) ? SETTLE_CNT - 1 : 0);
   localparam logic [AVG_W-1:0] AVG_LOAD = AVG_W'((1 << LOG2_AVG) - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACCUM  = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   localparam state_t START_ST = (SETTLE_CNT == 0) ? ACCUM : SETTLE;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [SET_W-1:0]  settle_rem_q, settle_rem_d;
   logic [AVG_W-1:0]  avg_rem_q, avg_rem_d;
   logic [DATA_W-1:0] avg_data_q, avg_data_d;
   logic [ADDR_W-1:0] avg_addr_q, avg_addr_d;
   logic              overrun_q, overrun_d;

   logic [ACC_W-1:0]  sum;
   logic [DATA_W-1:0] result;

`ifdef ADC_AVG_ROUND_EN
   localparam logic [ACC_W-1:0] RND_TERM = ACC_W'((1 << LOG2_AVG) / 2);
   localparam logic [ACC_W-1:0] DATA_MAX = ACC_W'((1 << DATA_W) - 1);
   logic [ACC_W-1:0] rnd_sum;
`endif

   always_comb begin
      sum = acc_q + ACC_W'(sample_data);
`ifdef ADC_AVG_ROUND_EN
      rnd_sum = (sum + RND_TERM) >> LOG2_AVG;
      result  = (rnd_sum > DATA_MAX) ? {DATA_W{1'b1}} : rnd_sum[DATA_W-1:0];
`else
      result  = DATA_W'(sum >> LOG2_AVG);
`endif
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      acc_d        = acc_q;
      settle_rem_d = settle_rem_q;
      avg_rem_d    = avg_rem_q;
      avg_data_d   = avg_data_q;
      avg_addr_d   = avg_addr_q;
      overrun_d    = overrun_q;

      // ch_start preempts everything; a coincident sample is dropped
      if (ch_start) begin
         state_d      = START_ST;
         cur_addr_d   = ch_addr;
         acc_d        = '0;
         settle_rem_d = SET_LOAD;
         avg_rem_d    = AVG_LOAD;
         if (state_q == SETTLE || state_q == ACCUM) overrun_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: ;
            SETTLE: begin
               if (sample_valid) begin
                  if (settle_rem_q == '0) state_d = ACCUM;
                  else settle_rem_d = settle_rem_q - SET_W'(1);
               end
            end
            ACCUM: begin
               if (sample_valid) begin
                  if (avg_rem_q == '0) begin
                     state_d    = OUTPUT;
                     avg_data_d = result;
                     avg_addr_d = cur_addr_q;
                  end else begin
                     acc_d     = sum;
                     avg_rem_d = avg_rem_q - AVG_W'(1);
                  end
               end
            end
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         acc_q        <= '0;
         settle_rem_q <= '0;
         avg_rem_q    <= '0;
         avg_data_q   <= '0;
         avg_addr_q   <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         acc_q        <= acc_d;
         settle_rem_q <= settle_rem_d;
         avg_rem_q    <= avg_rem_d;
         avg_data_q   <= avg_data_d;
         avg_addr_q   <= avg_addr_d;
         overrun_q    <= overrun_d;
      end
   end

   assign avg_valid = (state_q == OUTPUT);
   assign busy      = (state_q == SETTLE) || (state_q == ACCUM);
   assign avg_data  = avg_data_q;
   assign avg_addr  = avg_addr_q;
   assign overrun   = overrun_q;

endmodule
